ifft_frame_buf: RTL and testbench
=================================

Name: ifft_frame_buf

Overview:
- Collects frequency-shifted spectrum bins from raiseFreq (raise_data / raise_valid / freq_out / raise_fin) into 64-bin frames.
- Uses a two-bank ping-pong buffer.
- Streams each completed frame to the downstream IFFT with a valid/ready handshake, in bit-reversed or natural bin order.
- Decouples raiseFreq's free-running output from IFFT back-pressure.

Parameters:
- DW, 32, bin word width ({re[15:0], im[15:0]}, passed through untouched)
- AW, 6, bin index width
- N, 64, bins per frame (2**AW)
- BITREV, 1, 1 = output in bit-reversed index order, 0 = natural order

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- raise_data  in  DW  bin value from raiseFreq
- raise_valid  in  1  raise_data/freq_out valid this cycle
- freq_out  in  AW  bin index of raise_data
- raise_fin  in  1  qualified by raise_valid; marks last bin of frame
- out_data  out  DW  bin value to IFFT
- out_valid  out  1  out_data valid
- out_ready  in  1  IFFT accepts out_data
- out_idx  out  AW  bin index of out_data
- out_fin  out  1  last word of frame, coincident with out_valid
- overflow  out  1  sticky: a frame was dropped

Behaviour:
- Reset (rst=0, async): out_valid=0, out_fin=0, out_data=0, out_idx=0, overflow=0.
  - Reset also empties both banks, clears both written-bin bitmaps, sets write bank=0 and read FSM=IDLE.
  - Reset mid-frame discards all partial and full frames.
- Storage: two banks of N x DW. Each bank has an N-bit written bitmap and a full flag.
- Write side:
  - On raise_valid=1: store raise_data at [freq_out] of the write bank and set bitmap[freq_out].
  - A duplicate index within one frame: last write wins.
  - raise_fin without raise_valid is ignored.
  - raise_valid & raise_fin: write the bin, then set full[wbank] at the same edge.
  - If the other bank is empty at that edge, toggle wbank. Otherwise enter DROP.
- DROP (write side):
  - Entered when no free bank exists.
  - Bins are discarded, and overflow is set on the first dropped bin.
  - Exit DROP only after a raise_fin has been seen while in DROP and the other bank has been released.
  - On exit, write into the released bank, starting clean.
  - The full pending bank is never overwritten.
- Read FSM:
  - IDLE: if full[rbank], go to LOAD with cnt=0.
  - LOAD: issue a synchronous read of address A(cnt). A(cnt)=bitrev(cnt) if BITREV else cnt. Go to STREAM.
  - STREAM: out_valid=1. out_data = the word read, or 0 if its bitmap bit is clear. out_idx=A(cnt). out_fin=(cnt==N-1).
  - While out_valid & ~out_ready: hold all outputs stable.
  - On out_valid & out_ready with cnt<N-1: increment cnt and present the next word the following cycle. Zero-bubble streaming is required, so prefetch the next address.
  - On the handshake with cnt==N-1: release the bank (full=0, bitmap cleared), toggle rbank and go to IDLE.
- Latency:
  - The edge that samples raise_fin sets full.
  - out_valid rises 2 cycles after that edge when the read FSM is IDLE.
  - A full frame takes N cycles with out_ready held high.
- Simultaneous events:
  - Release of bank X and raise_fin completing bank Y in the same cycle: Y becomes full and the write side moves to X. No drop.
  - Release edge concurrent with the first write of a new frame into X: the write is honoured and its bitmap bit is set after the clear.
- Bitmap: an unwritten bin is output as 0, so short frames are tolerated.

Test Plan:
- Single frame, natural order:
  - Stimulus: BITREV=0. Write bins k=0..63 with data 32'h0001_0000*k + k, raise_fin on k=63, out_ready=1.
  - Required: out_valid rises 2 cycles after the fin edge. 64 consecutive words, out_idx 0..63, data matches, out_fin on word 63 only.
- Bit-reversed order:
  - Stimulus: same input with BITREV=1.
  - Required: out_idx sequence starts 0,32,16,48,8,40. Word 1 = bin 32 data. out_fin with out_idx=63.
- Back-pressure:
  - Stimulus: toggle out_ready 1,0,0,1 repeatedly.
  - Required: out_data/out_idx stable while stalled, no word lost or duplicated, all 64 delivered in order.
- Ping-pong and overflow:
  - Stimulus: out_ready=0. Send 3 back-to-back frames.
  - Required: frames 1 and 2 held. Frame 3 dropped and overflow=1.
  - Then release out_ready=1: frames 1 then 2 emerge intact.
  - Frame 4 sent after a release is accepted, and overflow stays 1.
- Sparse frame:
  - Stimulus: write only bins 3 (32'hDEAD_BEEF) and 60, fin on 60.
  - Required: 64 words out, bins 3 and 60 carry their data, the other 62 words are 0. The next frame's bitmap is clean.
- Reset mid-stream:
  - Stimulus: assert rst low at word 20 of output.
  - Required: out_valid=0 immediately (async), overflow=0.
  - After release, a new full frame streams normally with no remnants.

Source files
------------

// File: rtl/ifft_frame_buf_if.sv
// ifft_frame_buf_if: groups the two streaming links of the frame buffer.
//   raise side : raise_data / raise_valid / freq_out / raise_fin (raiseFreq -> buffer)
//   out side   : out_data / out_valid / out_ready / out_idx / out_fin (buffer -> IFFT)
// modport slave  : the frame buffer (consumes raise side, drives out side)
// modport master : the surrounding environment (source of bins, IFFT sink)
interface ifft_frame_buf_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [DW-1:0] raise_data;
  logic          raise_valid;
  logic [AW-1:0] freq_out;
  logic          raise_fin;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic          out_fin;

  modport slave (
    input  raise_data, raise_valid, freq_out, raise_fin, out_ready,
    output out_data, out_valid, out_idx, out_fin
  );

  modport master (
    output raise_data, raise_valid, freq_out, raise_fin, out_ready,
    input  out_data, out_valid, out_idx, out_fin
  );
endinterface

// File: rtl/ifft_frame_buf.sv
// ifft_frame_buf: collects raiseFreq bins into N-bin frames using a two-bank
// ping-pong buffer and streams each completed frame to the IFFT over a
// valid/ready link, in natural or bit-reversed bin order.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : raise_* input stream and out_* output stream (slave modport)
//   overflow : sticky, set when an incoming bin had to be discarded
// Unwritten bins of a frame read out as zero (per-bank written bitmap).
module ifft_frame_buf #(
  parameter int DW     = 32,
  parameter int AW     = 6,
  parameter int N      = 64,
  parameter int BITREV = 1
) (
  input  logic            clk,
  input  logic            rst,
  ifft_frame_buf_if.slave bus,
  output logic            overflow
);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

  logic [DW-1:0]     mem [2][N];
  logic [1:0][N-1:0] bitmap;
  logic [1:0]        full;
  logic              wbank, rbank;
  logic              drop, drop_fin;
  rd_state_t         state;
  logic [AW-1:0]     cnt;

  logic              rel, drop_free, exit_now, tgt, wr_en, fin_wr, next_free;
  logic [AW-1:0]     nxt_cnt, raddr;
  logic [DW-1:0]     rword;

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] c);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = c[AW-1-i];
    return (BITREV != 0) ? r : c;
  endfunction

  always_comb begin
    // Last word of the read bank is accepted this edge: that bank frees up now.
    rel       = (state == STREAM) && bus.out_ready && (cnt == LAST);
    // While dropping, wbank still points at the completed (full) bank; the
    // bank to resume into is the other one, which is the one being read.
    drop_free = !full[~wbank] || (rel && (rbank != wbank));
    exit_now  = drop && drop_fin && drop_free;
    tgt       = drop ? ~wbank : wbank;
    wr_en     = bus.raise_valid && (!drop || exit_now);
    fin_wr    = wr_en && bus.raise_fin;
    next_free = !full[~tgt] || (rel && (rbank != tgt));
    // Address prefetch: the word for the next count is read on the same edge
    // that accepts the current one, so streaming has no bubbles.
    nxt_cnt   = (state == STREAM) ? cnt + AW'(1) : cnt;
    raddr     = addr_of(nxt_cnt);
    rword     = bitmap[rbank][raddr] ? mem[rbank][raddr] : '0;
  end

  // Bin storage: no reset, validity is tracked by the bitmaps.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tgt][bus.freq_out] <= bus.raise_data;
  end

  // Write side: bank bookkeeping, drop handling and overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank    <= 1'b0;
      drop     <= 1'b0;
      drop_fin <= 1'b0;
      overflow <= 1'b0;
      full     <= '0;
      bitmap   <= '0;
    end else begin
      if (rel) begin
        full[rbank]   <= 1'b0;
        bitmap[rbank] <= '0;
      end
      // Placed after the release clear so a write into a bank released on the
      // same edge keeps its bit.
      if (wr_en) bitmap[tgt][bus.freq_out] <= 1'b1;
      if (fin_wr) begin
        full[tgt] <= 1'b1;
        drop_fin  <= 1'b0;
        if (next_free) begin
          wbank <= ~tgt;
          drop  <= 1'b0;
        end else begin
          wbank <= tgt;
          drop  <= 1'b1;
        end
      end else if (exit_now) begin
        wbank    <= tgt;
        drop     <= 1'b0;
        drop_fin <= 1'b0;
      end else if (drop && bus.raise_valid) begin
        // Discarded bin; a fin here marks the frame boundary at which
        // writing may resume once a bank is free.
        overflow <= 1'b1;
        drop_fin <= bus.raise_fin;
      end
    end
  end

  // Read side: IDLE -> LOAD -> STREAM, outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rbank         <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_fin   <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= rword;
          bus.out_idx   <= raddr;
          bus.out_fin   <= (nxt_cnt == LAST);
          state         <= STREAM;
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (cnt == LAST) begin
              bus.out_valid <= 1'b0;
              bus.out_fin   <= 1'b0;
              rbank         <= ~rbank;
              state         <= IDLE;
            end else begin
              cnt           <= nxt_cnt;
              bus.out_data  <= rword;
              bus.out_idx   <= raddr;
              bus.out_fin   <= (nxt_cnt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft_frame_buf.sv
// Bench for ifft_frame_buf: one natural-order and one bit-reversed instance
// share the same bin stream. The reference model keeps completed frames as
// plain 64-word arrays in a queue (unwritten bins = 0, last write wins, a
// frame is dropped when two frames are already held).
module tb_ifft_frame_buf;
  typedef logic [63:0][31:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic [5:0]  rfreq = '0;
  logic        rfin = 1'b0;
  logic        rdy_nat = 1'b0;
  logic        ovf_nat, ovf_rev;

  ifft_frame_buf_if #(.DW(32), .AW(6)) if_nat ();
  ifft_frame_buf_if #(.DW(32), .AW(6)) if_rev ();

  assign if_nat.raise_data  = rdata;
  assign if_nat.raise_valid = rvalid;
  assign if_nat.freq_out    = rfreq;
  assign if_nat.raise_fin   = rfin;
  assign if_nat.out_ready   = rdy_nat;
  assign if_rev.raise_data  = rdata;
  assign if_rev.raise_valid = rvalid;
  assign if_rev.freq_out    = rfreq;
  assign if_rev.raise_fin   = rfin;
  assign if_rev.out_ready   = 1'b1;

  ifft_frame_buf #(.DW(32), .AW(6), .N(64), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .bus(if_nat), .overflow(ovf_nat));
  ifft_frame_buf #(.DW(32), .AW(6), .N(64), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .bus(if_rev), .overflow(ovf_rev));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  frame_t      exp_q[$];
  logic        m_ovf = 1'b0;
  int          s_idx[$];
  logic [31:0] s_dat[$];

  // collected output
  logic [31:0] g_data [64];
  logic [5:0]  g_idx  [64];
  logic        g_fin  [64];
  int          g_n, g_lat, g_gap, g_stall;

  function automatic int brev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) r += (1 << (5 - b));
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b0; rfin = 1'b0; rdy_nat = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_frame();
    s_idx.delete(); s_dat.delete();
    for (int k = 0; k < 64; k++) begin
      s_idx.push_back(k);
      s_dat.push_back($urandom);
    end
  endtask

  // Drives the queued bins (fin on the last), optionally with a stray
  // fin-without-valid cycle, then updates the reference model.
  task automatic send_frame(input int stray_at);
    frame_t f;
    for (int i = 0; i < s_idx.size(); i++) begin
      if (i == stray_at) begin
        @(negedge clk);
        rvalid = 1'b0; rfin = 1'b1; rdata = $urandom;
      end
      @(negedge clk);
      rvalid = 1'b1;
      rfreq  = 6'(s_idx[i]);
      rdata  = s_dat[i];
      rfin   = (i == s_idx.size() - 1);
    end
    @(negedge clk);
    rvalid = 1'b0; rfin = 1'b0;
    f = '0;
    foreach (s_idx[i]) f[s_idx[i]] = s_dat[i];
    if (exp_q.size() < 2) exp_q.push_back(f);
    else m_ovf = 1'b1;
  endtask

  // Gathers one frame from the chosen instance. mode 0: ready always high,
  // mode 1: ready pattern 1,0,0,1. Records latency, bubbles and stall changes.
  task automatic collect(input bit rev, input int mode);
    int t, cyc;
    logic pv, pf, v, f, r;
    logic [31:0] pd, d;
    logic [5:0] pi, ix;
    g_n = 0; g_lat = -1; g_gap = 0; g_stall = 0;
    t = 0; cyc = 0; pv = 1'b0; pd = '0; pi = '0; pf = 1'b0;
    while (g_n < 64 && t < 3000) begin
      v  = rev ? if_rev.out_valid : if_nat.out_valid;
      d  = rev ? if_rev.out_data  : if_nat.out_data;
      ix = rev ? if_rev.out_idx   : if_nat.out_idx;
      f  = rev ? if_rev.out_fin   : if_nat.out_fin;
      r  = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (rev) r = 1'b1;
      if (v && g_lat < 0) g_lat = t;
      if (pv && (!v || d !== pd || ix !== pi || f !== pf)) g_stall++;
      if (g_n > 0 && !v) g_gap++;
      if (v) cyc++;
      if (!rev) rdy_nat = r;
      if (v && r) begin
        g_data[g_n] = d; g_idx[g_n] = ix; g_fin[g_n] = f;
        g_n++;
      end
      pv = v && !r; pd = d; pi = ix; pf = f;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_chk++; if (if_nat.out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_nat.out_valid); else n_pass++;
    n_chk++; if (if_nat.out_fin !== 1'b0) $display("FAIL rst_fin got %b exp 0", if_nat.out_fin); else n_pass++;
    n_chk++; if (if_nat.out_data !== 32'h0) $display("FAIL rst_data got %h exp 0", if_nat.out_data); else n_pass++;
    n_chk++; if (if_nat.out_idx !== 6'h0) $display("FAIL rst_idx got %0d exp 0", if_nat.out_idx); else n_pass++;
    n_chk++; if (ovf_nat !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf_nat); else n_pass++;
    n_chk++; if (if_rev.out_valid !== 1'b0) $display("FAIL rst_rev_valid got %b exp 0", if_rev.out_valid); else n_pass++;
    do_reset();
  endtask

  task automatic test_natural();
    frame_t f;
    do_reset();
    s_idx.delete(); s_dat.delete();
    for (int k = 0; k < 64; k++) begin
      s_idx.push_back(k);
      s_dat.push_back(32'h0001_0000 * k + k);
    end
    send_frame(-1);
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL nat_count got %0d exp 64", g_n); else n_pass++;
    n_chk++; if (g_lat !== 2) $display("FAIL nat_latency got %0d exp 2", g_lat); else n_pass++;
    n_chk++; if (g_gap !== 0) $display("FAIL nat_bubbles got %0d exp 0", g_gap); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_idx[w] !== 6'(w)) $display("FAIL nat_idx w=%0d got %0d exp %0d", w, g_idx[w], w); else n_pass++;
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL nat_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
      n_chk++; if (g_fin[w] !== (w == 63)) $display("FAIL nat_fin w=%0d got %b exp %b", w, g_fin[w], (w == 63)); else n_pass++;
    end
  endtask

  task automatic test_bitrev();
    frame_t f;
    int first6[6];
    first6 = '{0, 32, 16, 48, 8, 40};
    do_reset();
    rand_frame();
    send_frame(-1);
    f = exp_q[0];
    collect(1'b1, 0);
    n_chk++; if (g_n !== 64) $display("FAIL rev_count got %0d exp 64", g_n); else n_pass++;
    n_chk++; if (g_lat !== 2) $display("FAIL rev_latency got %0d exp 2", g_lat); else n_pass++;
    for (int w = 0; w < 6; w++) begin
      n_chk++; if (g_idx[w] !== 6'(first6[w])) $display("FAIL rev_head w=%0d got %0d exp %0d", w, g_idx[w], first6[w]); else n_pass++;
    end
    n_chk++; if (g_data[1] !== f[32]) $display("FAIL rev_word1 got %h exp %h", g_data[1], f[32]); else n_pass++;
    n_chk++; if (g_idx[63] !== 6'd63 || g_fin[63] !== 1'b1) $display("FAIL rev_fin_idx got %0d/%b exp 63/1", g_idx[63], g_fin[63]); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_idx[w] !== 6'(brev6(w))) $display("FAIL rev_idx w=%0d got %0d exp %0d", w, g_idx[w], brev6(w)); else n_pass++;
      n_chk++; if (g_data[w] !== f[brev6(w)]) $display("FAIL rev_data w=%0d got %h exp %h", w, g_data[w], f[brev6(w)]); else n_pass++;
      n_chk++; if (g_fin[w] !== (w == 63)) $display("FAIL rev_fin w=%0d got %b exp %b", w, g_fin[w], (w == 63)); else n_pass++;
    end
    // the natural-order instance held the same frame meanwhile
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL rev_nat_count got %0d exp 64", g_n); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL rev_nat_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    frame_t f;
    int j, tmp;
    do_reset();
    rand_frame();
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = s_idx[i]; s_idx[i] = s_idx[j]; s_idx[j] = tmp;
    end
    send_frame(-1);
    collect(1'b0, 1);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL bp_count got %0d exp 64", g_n); else n_pass++;
    n_chk++; if (g_stall !== 0) $display("FAIL bp_stall_changes got %0d exp 0", g_stall); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_idx[w] !== 6'(w)) $display("FAIL bp_idx w=%0d got %0d exp %0d", w, g_idx[w], w); else n_pass++;
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL bp_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
      n_chk++; if (g_fin[w] !== (w == 63)) $display("FAIL bp_fin w=%0d got %b exp %b", w, g_fin[w], (w == 63)); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    frame_t f;
    do_reset();
    rdy_nat = 1'b0;
    rand_frame(); send_frame(-1);
    rand_frame(); send_frame(-1);
    n_chk++; if (ovf_nat !== m_ovf) $display("FAIL ovf_after2 got %b exp %b", ovf_nat, m_ovf); else n_pass++;
    rand_frame(); send_frame(-1);
    n_chk++; if (ovf_nat !== m_ovf) $display("FAIL ovf_after3 got %b exp %b", ovf_nat, m_ovf); else n_pass++;
    n_chk++; if (if_nat.out_valid !== 1'b1 || if_nat.out_idx !== 6'd0) $display("FAIL ovf_head_held got %b/%0d exp 1/0", if_nat.out_valid, if_nat.out_idx); else n_pass++;
    for (int fr = 0; fr < 2; fr++) begin
      collect(1'b0, 0);
      f = exp_q.pop_front();
      n_chk++; if (g_n !== 64) $display("FAIL ovf_count fr=%0d got %0d exp 64", fr, g_n); else n_pass++;
      for (int w = 0; w < g_n; w++) begin
        n_chk++; if (g_data[w] !== f[w]) $display("FAIL ovf_data fr=%0d w=%0d got %h exp %h", fr, w, g_data[w], f[w]); else n_pass++;
      end
    end
    rand_frame(); send_frame(-1);
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL ovf_f4_count got %0d exp 64", g_n); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL ovf_f4_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
    end
    n_chk++; if (ovf_nat !== m_ovf) $display("FAIL ovf_sticky got %b exp %b", ovf_nat, m_ovf); else n_pass++;
  endtask

  task automatic test_sparse();
    frame_t f;
    do_reset();
    s_idx.delete(); s_dat.delete();
    s_idx.push_back(3);  s_dat.push_back(32'hDEAD_BEEF);
    s_idx.push_back(60); s_dat.push_back($urandom);
    send_frame(-1);
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL sp_count got %0d exp 64", g_n); else n_pass++;
    n_chk++; if (g_data[3] !== 32'hDEAD_BEEF) $display("FAIL sp_bin3 got %h exp deadbeef", g_data[3]); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL sp_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
    end
    // second frame: duplicate bin 5 and a stray fin without valid
    s_idx.delete(); s_dat.delete();
    s_idx.push_back(5);  s_dat.push_back($urandom);
    s_idx.push_back(5);  s_dat.push_back($urandom);
    s_idx.push_back(10); s_dat.push_back($urandom);
    send_frame(1);
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL sp2_count got %0d exp 64", g_n); else n_pass++;
    n_chk++; if (g_data[60] !== 32'h0) $display("FAIL sp2_clean60 got %h exp 0", g_data[60]); else n_pass++;
    for (int w = 0; w < g_n; w++) begin
      n_chk++; if (g_data[w] !== f[w]) $display("FAIL sp2_data w=%0d got %h exp %h", w, g_data[w], f[w]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    int w, t;
    do_reset();
    rdy_nat = 1'b0;
    for (int fr = 0; fr < 3; fr++) begin
      rand_frame(); send_frame(-1);
    end
    n_chk++; if (ovf_nat !== m_ovf) $display("FAIL rm_ovf_pre got %b exp %b", ovf_nat, m_ovf); else n_pass++;
    rdy_nat = 1'b1;
    w = 0; t = 0;
    while (w < 20 && t < 3000) begin
      if (if_nat.out_valid) w++;
      @(negedge clk);
      t++;
    end
    n_chk++; if (if_nat.out_idx !== 6'd20 || w !== 20) $display("FAIL rm_word20 got idx %0d cnt %0d exp 20", if_nat.out_idx, w); else n_pass++;
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    n_chk++; if (if_nat.out_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", if_nat.out_valid); else n_pass++;
    n_chk++; if (ovf_nat !== 1'b0) $display("FAIL rm_ovf got %b exp 0", ovf_nat); else n_pass++;
    n_chk++; if (if_nat.out_data !== 32'h0 || if_nat.out_fin !== 1'b0) $display("FAIL rm_data_fin got %h/%b exp 0/0", if_nat.out_data, if_nat.out_fin); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rand_frame(); send_frame(-1);
    collect(1'b0, 0);
    f = exp_q.pop_front();
    n_chk++; if (g_n !== 64) $display("FAIL rm_count got %0d exp 64", g_n); else n_pass++;
    for (int k = 0; k < g_n; k++) begin
      n_chk++; if (g_data[k] !== f[k]) $display("FAIL rm_data w=%0d got %h exp %h", k, g_data[k], f[k]); else n_pass++;
    end
    repeat (8) @(negedge clk);
    n_chk++; if (if_nat.out_valid !== 1'b0) $display("FAIL rm_no_remnant got %b exp 0", if_nat.out_valid); else n_pass++;
    n_chk++; if (ovf_nat !== m_ovf) $display("FAIL rm_ovf_post got %b exp %b", ovf_nat, m_ovf); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_overflow();
    test_sparse();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
